// File: rtl/piso_tx.sv
// piso_tx -- parallel-in serial-out transmitter.
//
// Takes a WIDTH-bit word through a valid/ready handshake and shifts it out one
// bit per clock. frame_start and frame_end mark the first and last bit of each
// word. A new word can be accepted while the last bit is on the line, so
// consecutive words stream without an idle cycle.
//
// Parameters:
//   WIDTH      word width in bits (>= 1)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   load_valid    parallel_in holds a word to send
//   load_ready    a word can be taken this cycle
//   parallel_in   word to serialize, sampled only on accept
//   serial_out    registered serial data bit
//   serial_valid  serial_out carries a frame bit
//   frame_start   first bit of a word is on serial_out
//   frame_end     last bit of a word is on serial_out
//   busy          same as serial_valid
module piso_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    // The counter keeps at least one bit so WIDTH=1 still elaborates.
    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             so_q, so_d;
    logic             fs_q, fs_d;
    logic             fe_q, fe_d;
    logic             accept;

    // Bit that leaves first from a word held in the shift register.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST)
            return w[WIDTH-1];
        else
            return w[0];
    endfunction

    assign serial_valid = (state_q == SHIFT);
    assign busy         = serial_valid;
    assign serial_out   = so_q;
    assign frame_start  = fs_q;
    assign frame_end    = fe_q;

    // Ready while idle, and also on the last bit so the next word follows
    // with no gap.
    assign load_ready   = !serial_valid || fe_q;
    assign accept       = load_valid && load_ready;

    // Shift register keeps the word with the bit currently on the line at the
    // head position; advancing moves the next bit into the head.
    assign shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        so_d    = so_q;
        fs_d    = fs_q;
        fe_d    = fe_q;

        if (accept) begin
            state_d = SHIFT;
            shreg_d = parallel_in;
            cnt_d   = '0;
            so_d    = head_bit(parallel_in);
            fs_d    = 1'b1;
            fe_d    = (LAST == '0);
        end else begin
            case (state_q)
                IDLE: begin
                    so_d = 1'b0;
                    fs_d = 1'b0;
                    fe_d = 1'b0;
                end
                SHIFT: begin
                    if (fe_q) begin
                        state_d = IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                        so_d    = 1'b0;
                        fs_d    = 1'b0;
                        fe_d    = 1'b0;
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + 1'b1;
                        so_d    = head_bit(shifted);
                        fs_d    = 1'b0;
                        fe_d    = (cnt_d == LAST);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            so_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // MSB-first, WIDTH=4
    logic       lv_m = 1'b0;
    logic       rdy_m;
    logic [3:0] pin_m = '0;
    logic       so_m, sv_m, fs_m, fe_m, busy_m;

    // LSB-first, WIDTH=4
    logic       lv_l = 1'b0;
    logic       rdy_l;
    logic [3:0] pin_l = '0;
    logic       so_l, sv_l, fs_l, fe_l, busy_l;

    // WIDTH=1
    logic       lv_1 = 1'b0;
    logic       rdy_1;
    logic [0:0] pin_1 = '0;
    logic       so_1, sv_1, fs_1, fe_1, busy_1;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .load_valid(lv_m), .load_ready(rdy_m),
        .parallel_in(pin_m), .serial_out(so_m), .serial_valid(sv_m),
        .frame_start(fs_m), .frame_end(fe_m), .busy(busy_m)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load_valid(lv_l), .load_ready(rdy_l),
        .parallel_in(pin_l), .serial_out(so_l), .serial_valid(sv_l),
        .frame_start(fs_l), .frame_end(fe_l), .busy(busy_l)
    );

    piso_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_w1 (
        .clk(clk), .rst(rst), .load_valid(lv_1), .load_ready(rdy_1),
        .parallel_in(pin_1), .serial_out(so_1), .serial_valid(sv_1),
        .frame_start(fs_1), .frame_end(fe_1), .busy(busy_1)
    );

    // Advance one edge; outputs are then sampled 1 time unit after it and new
    // inputs apply to the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        lv_m  = 1'b1;
        pin_m = 4'b1011;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({sv_m, so_m, fs_m, fe_m, busy_m} !== 5'b00000) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got sv/so/fs/fe/busy=%b expected 00000", i,
                         {sv_m, so_m, fs_m, fe_m, busy_m});
            end
            checks++;
            if (rdy_m !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready[%0d]: got %b expected 1", i, rdy_m);
            end
        end
        lv_m = 1'b0;
        rst  = 1'b0;
        tick();
        checks++;
        if (sv_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_nothing_sent: got sv=%b expected 0", sv_m);
        end
    endtask

    task automatic test_single_word();
        logic [3:0] exp_bits;
        exp_bits = 4'b1011;
        lv_m  = 1'b1;
        pin_m = 4'b1011;
        checks++;
        if (rdy_m !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_idle: got %b expected 1", rdy_m);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            lv_m = 1'b0;
            checks++;
            if ({sv_m, so_m, fs_m, fe_m} !== {1'b1, exp_bits[3-i], i == 0, i == 3}) begin
                errors++;
                $display("FAIL single_bit[%0d]: got sv/so/fs/fe=%b expected %b", i,
                         {sv_m, so_m, fs_m, fe_m}, {1'b1, exp_bits[3-i], i == 0, i == 3});
            end
            checks++;
            if (rdy_m !== (i == 3)) begin
                errors++;
                $display("FAIL single_ready[%0d]: got %b expected %b", i, rdy_m, i == 3);
            end
        end
        tick();
        checks++;
        if ({sv_m, so_m, fs_m, fe_m, busy_m} !== 5'b00000) begin
            errors++;
            $display("FAIL single_idle: got sv/so/fs/fe/busy=%b expected 00000",
                     {sv_m, so_m, fs_m, fe_m, busy_m});
        end
    endtask

    // Two words with load_valid held; second word is switched in after the
    // first accept and must follow with no gap.
    task automatic stream_two(input string name, input logic [3:0] w0, input logic [3:0] w1);
        logic [7:0] exp_bits;
        exp_bits = {w0, w1};
        lv_m  = 1'b1;
        pin_m = w0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({sv_m, so_m, fs_m, fe_m} !==
                {1'b1, exp_bits[7-i], (i == 0) || (i == 4), (i == 3) || (i == 7)}) begin
                errors++;
                $display("FAIL %s_bit[%0d]: got sv/so/fs/fe=%b expected %b", name, i,
                         {sv_m, so_m, fs_m, fe_m},
                         {1'b1, exp_bits[7-i], (i == 0) || (i == 4), (i == 3) || (i == 7)});
            end
            if (i == 0) pin_m = w1;
            if (i == 4) lv_m = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({sv_m, so_m} !== 2'b00) begin
                errors++;
                $display("FAIL %s_idle[%0d]: got sv/so=%b expected 00", name, i, {sv_m, so_m});
            end
        end
    endtask

    task automatic test_back_to_back();
        stream_two("b2b", 4'b1111, 4'b0001);
    endtask

    task automatic test_input_change();
        stream_two("midchange", 4'b1000, 4'b0101);
    endtask

    task automatic test_abort();
        logic [3:0] exp_bits;
        lv_m  = 1'b1;
        pin_m = 4'b0101;
        tick();
        lv_m = 1'b0;
        checks++;
        if ({sv_m, so_m, fs_m} !== 3'b101) begin
            errors++;
            $display("FAIL abort_bit0: got sv/so/fs=%b expected 101", {sv_m, so_m, fs_m});
        end
        tick();
        checks++;
        if ({sv_m, so_m, fs_m} !== 3'b110) begin
            errors++;
            $display("FAIL abort_bit1: got sv/so/fs=%b expected 110", {sv_m, so_m, fs_m});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({sv_m, so_m, fs_m, fe_m, rdy_m} !== 5'b00001) begin
            errors++;
            $display("FAIL abort_reset: got sv/so/fs/fe/rdy=%b expected 00001",
                     {sv_m, so_m, fs_m, fe_m, rdy_m});
        end
        exp_bits = 4'b1000;
        lv_m  = 1'b1;
        pin_m = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            lv_m = 1'b0;
            checks++;
            if ({sv_m, so_m, fs_m, fe_m} !== {1'b1, exp_bits[3-i], i == 0, i == 3}) begin
                errors++;
                $display("FAIL abort_resend[%0d]: got sv/so/fs/fe=%b expected %b", i,
                         {sv_m, so_m, fs_m, fe_m}, {1'b1, exp_bits[3-i], i == 0, i == 3});
            end
        end
        tick();
        checks++;
        if (sv_m !== 1'b0) begin
            errors++;
            $display("FAIL abort_resend_idle: got sv=%b expected 0", sv_m);
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp_seq;
        exp_seq = 4'b1101; // serial order, first bit leftmost
        lv_l  = 1'b1;
        pin_l = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            tick();
            lv_l = 1'b0;
            checks++;
            if ({sv_l, so_l, fs_l, fe_l} !== {1'b1, exp_seq[3-i], i == 0, i == 3}) begin
                errors++;
                $display("FAIL lsb_bit[%0d]: got sv/so/fs/fe=%b expected %b", i,
                         {sv_l, so_l, fs_l, fe_l}, {1'b1, exp_seq[3-i], i == 0, i == 3});
            end
        end
        tick();
        checks++;
        if ({sv_l, so_l} !== 2'b00) begin
            errors++;
            $display("FAIL lsb_idle: got sv/so=%b expected 00", {sv_l, so_l});
        end
    endtask

    task automatic test_width1();
        lv_1  = 1'b1;
        pin_1 = 1'b1;
        tick();
        pin_1 = 1'b0;
        checks++;
        if ({sv_1, so_1, fs_1, fe_1, rdy_1} !== 5'b11111) begin
            errors++;
            $display("FAIL w1_bit0: got sv/so/fs/fe/rdy=%b expected 11111",
                     {sv_1, so_1, fs_1, fe_1, rdy_1});
        end
        tick();
        lv_1 = 1'b0;
        checks++;
        if ({sv_1, so_1, fs_1, fe_1} !== 4'b1011) begin
            errors++;
            $display("FAIL w1_bit1: got sv/so/fs/fe=%b expected 1011", {sv_1, so_1, fs_1, fe_1});
        end
        tick();
        checks++;
        if ({sv_1, so_1, fs_1, fe_1} !== 4'b0000) begin
            errors++;
            $display("FAIL w1_idle: got sv/so/fs/fe=%b expected 0000", {sv_1, so_1, fs_1, fe_1});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_input_change();
        test_abort();
        test_lsb_first();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
